// File: rtl/sme_pattern_scheduler.sv
// sme_pattern_scheduler: front-end for the string-match engine (SME).
// Holds one host-loaded string (up to 32 chars), round-robin grants pattern jobs from NREQ
// requesters, streams string (when dirty) then pattern chars to the SME, waits for its result
// and hands it back tagged with the requester id. One job is in flight at a time.
// Optional build macro SME_TIMEOUT_EN bounds the WAIT state by TIMEOUT cycles and flags res_err.
module sme_pattern_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  // string load
  input  logic                 str_we,
  input  logic [4:0]           str_addr,
  input  logic [7:0]           str_data,
  input  logic                 str_commit,
  input  logic [5:0]           str_len_in,
  output logic                 str_ready,
  // pattern requesters
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*64-1:0]   req_pattern,
  input  logic [NREQ*4-1:0]    req_len,
  output logic [NREQ-1:0]      req_ready,
  // SME side
  output logic [7:0]           sme_chardata,
  output logic                 sme_isstring,
  output logic                 sme_ispattern,
  input  logic                 sme_valid,
  input  logic                 sme_match,
  input  logic [4:0]           sme_index,
  // result
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic                 res_match,
  output logic [4:0]           res_index,
  output logic                 res_err
);

  // Elaboration-time guard on parameter consistency.
  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_params
    $error("sme_pattern_scheduler: inconsistent NREQ/IDW/TIMEOUT");
  end

  typedef enum logic [2:0] {StIdle, StSendStr, StSendPat, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [255:0]      buf_q, buf_d;
  logic [5:0]        str_len_q, str_len_d;
  logic              dirty_q, dirty_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [63:0]       pat_q, pat_d;
  logic [3:0]        plen_q, plen_d;
  logic [4:0]        k_q, k_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic              res_match_q, res_match_d;
  logic [4:0]        res_index_q, res_index_d;

  logic              idle_active;
  logic              wr_en, commit_en;
  logic [5:0]        len_in_clamped;
  logic [5:0]        str_len_eff;
  logic              dirty_eff;
  logic              grant_any, grant;
  logic [IDW-1:0]    grant_idx, cand;
  logic [3:0]        req_len_raw, req_len_clamped;
  logic              last_str, last_pat;
  logic              timeout;

  // Reset also gates the IDLE-only handshakes so every output reads 0 while reset is held.
  assign idle_active = (state_q == StIdle) && !reset;
  assign wr_en       = idle_active && str_we;
  assign commit_en   = idle_active && str_commit;

  assign len_in_clamped = (str_len_in == 6'd0) ? 6'd1 :
                          (str_len_in > 6'd32) ? 6'd32 : str_len_in;
  // A commit in the grant cycle applies before the grant decision.
  assign str_len_eff = commit_en ? len_in_clamped : str_len_q;
  assign dirty_eff   = dirty_q || commit_en;

  assign last_str = (k_q == 5'(str_len_q - 6'd1));
  assign last_pat = (k_q == {1'b0, plen_q - 4'd1});

  // Round-robin arbiter: search starts one past the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_grant_q;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(last_grant_q) + i) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant = idle_active && grant_any && (str_len_eff != 6'd0);

  assign req_len_raw     = req_len[{grant_idx, 2'b00} +: 4];
  assign req_len_clamped = (req_len_raw == 4'd0) ? 4'd1 :
                           (req_len_raw > 4'd8)  ? 4'd8 : req_len_raw;

`ifdef SME_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1) + 1;

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           res_err_q, res_err_d;

  assign timeout = (state_q == StWait) && !sme_valid && (to_cnt_q == ToW'(TIMEOUT));

  // WAIT watchdog counter and the error flag it raises.
  always_comb begin
    to_cnt_d  = '0;
    res_err_d = res_err_q;
    if (state_q == StWait) begin
      to_cnt_d = to_cnt_q + ToW'(1);
      if (sme_valid) begin
        res_err_d = 1'b0;
      end else if (timeout) begin
        res_err_d = 1'b1;
      end
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      res_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

  // Datapath next-state: string buffer, job capture, char counter and result capture.
  always_comb begin
    buf_d        = buf_q;
    str_len_d    = str_len_q;
    dirty_d      = dirty_q;
    last_grant_d = last_grant_q;
    pat_d        = pat_q;
    plen_d       = plen_q;
    k_d          = k_q;
    res_id_d     = res_id_q;
    res_match_d  = res_match_q;
    res_index_d  = res_index_q;

    if (wr_en) begin
      buf_d[{str_addr, 3'b000} +: 8] = str_data;
    end
    if (commit_en) begin
      str_len_d = len_in_clamped;
      dirty_d   = 1'b1;
    end
    if (grant) begin
      last_grant_d = grant_idx;
      pat_d        = req_pattern[{grant_idx, 6'b000000} +: 64];
      plen_d       = req_len_clamped;
      k_d          = '0;
    end

    unique case (state_q)
      StSendStr: begin
        if (last_str) begin
          k_d     = '0;
          dirty_d = 1'b0;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      StSendPat: begin
        k_d = last_pat ? 5'd0 : k_q + 5'd1;
      end
      StWait: begin
        if (sme_valid) begin
          res_id_d    = last_grant_q;
          res_match_d = sme_match;
          res_index_d = sme_match ? sme_index : 5'd0;
        end else if (timeout) begin
          // The SME state is unknown after a timeout, so force a string resend.
          res_id_d    = last_grant_q;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          dirty_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant) state_d = dirty_eff ? StSendStr : StSendPat;
      StSendStr: if (last_str) state_d = StSendPat;
      StSendPat: if (last_pat) state_d = StWait;
      StWait:    if (sme_valid || timeout) state_d = StResp;
      StResp:    if (res_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    str_ready     = idle_active;
    req_ready     = grant ? (NREQ'(1) << grant_idx) : '0;
    sme_isstring  = 1'b0;
    sme_ispattern = 1'b0;
    sme_chardata  = 8'd0;
    res_valid     = (state_q == StResp);
    unique case (state_q)
      StSendStr: begin
        sme_isstring = 1'b1;
        sme_chardata = buf_q[{k_q, 3'b000} +: 8];
      end
      StSendPat: begin
        sme_ispattern = 1'b1;
        sme_chardata  = pat_q[{k_q[2:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign res_id    = res_id_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      buf_q        <= '0;
      str_len_q    <= '0;
      dirty_q      <= 1'b0;
      last_grant_q <= '0;
      pat_q        <= '0;
      plen_q       <= '0;
      k_q          <= '0;
      res_id_q     <= '0;
      res_match_q  <= 1'b0;
      res_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      str_len_q    <= str_len_d;
      dirty_q      <= dirty_d;
      last_grant_q <= last_grant_d;
      pat_q        <= pat_d;
      plen_q       <= plen_d;
      k_q          <= k_d;
      res_id_q     <= res_id_d;
      res_match_q  <= res_match_d;
      res_index_q  <= res_index_d;
    end
  end

endmodule

// File: tb/tb_sme_pattern_scheduler.sv
// Directed bench for sme_pattern_scheduler; inputs change 1 time unit after the rising edge and
// outputs are sampled in the same window. Timeout section runs only with SME_TIMEOUT_EN.
module tb_sme_pattern_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned TbTimeout =
`ifdef SME_TIMEOUT_EN
    20;
`else
    255;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                str_we, str_commit, str_ready;
  logic [4:0]          str_addr;
  logic [7:0]          str_data;
  logic [5:0]          str_len_in;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*64-1:0]  req_pattern;
  logic [NREQ*4-1:0]   req_len;
  logic [7:0]          sme_chardata;
  logic                sme_isstring, sme_ispattern, sme_valid, sme_match;
  logic [4:0]          sme_index;
  logic                res_valid, res_ready, res_match, res_err;
  logic [IDW-1:0]      res_id;
  logic [4:0]          res_index;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tb_buf [32];
  logic [63:0] tb_pat [NREQ];
  int          tb_len [NREQ];

  always #5 clk = ~clk;

  sme_pattern_scheduler #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TbTimeout)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .str_we        (str_we),
    .str_addr      (str_addr),
    .str_data      (str_data),
    .str_commit    (str_commit),
    .str_len_in    (str_len_in),
    .str_ready     (str_ready),
    .req_valid     (req_valid),
    .req_pattern   (req_pattern),
    .req_len       (req_len),
    .req_ready     (req_ready),
    .sme_chardata  (sme_chardata),
    .sme_isstring  (sme_isstring),
    .sme_ispattern (sme_ispattern),
    .sme_valid     (sme_valid),
    .sme_match     (sme_match),
    .sme_index     (sme_index),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_id        (res_id),
    .res_match     (res_match),
    .res_index     (res_index),
    .res_err       (res_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input int addr, input logic [7:0] data);
    str_we   = 1'b1;
    str_addr = 5'(addr);
    str_data = data;
    tick();
    str_we   = 1'b0;
    tb_buf[addr] = data;
  endtask

  // Called in the cycle after the grant; checks every SME char, returns in the first WAIT cycle.
  task automatic expect_stream(input string tag, input int slen, input logic [63:0] pat,
                               input int plen);
    for (int i = 0; i < slen; i++) begin
      check_eq({tag, "_isstr"}, 64'(sme_isstring), 64'd1);
      check_eq({tag, "_ispat0"}, 64'(sme_ispattern), 64'd0);
      check_eq({tag, "_schar"}, 64'(sme_chardata), 64'(tb_buf[i]));
      check_eq({tag, "_busy_rr"}, 64'(req_ready), 64'd0);
      tick();
    end
    for (int j = 0; j < plen; j++) begin
      check_eq({tag, "_ispat"}, 64'(sme_ispattern), 64'd1);
      check_eq({tag, "_isstr0"}, 64'(sme_isstring), 64'd0);
      check_eq({tag, "_pchar"}, 64'(sme_chardata), 64'(pat[j*8 +: 8]));
      tick();
    end
    check_eq({tag, "_wait_isstr"}, 64'(sme_isstring), 64'd0);
    check_eq({tag, "_wait_ispat"}, 64'(sme_ispattern), 64'd0);
    check_eq({tag, "_wait_char"}, 64'(sme_chardata), 64'd0);
    check_eq({tag, "_wait_resv"}, 64'(res_valid), 64'd0);
  endtask

  // Called in WAIT: return an SME result, check the response, then complete the handshake.
  task automatic finish_job(input string tag, input logic m, input logic [4:0] idx,
                            input int id, input logic [4:0] exp_idx);
    sme_valid = 1'b1;
    sme_match = m;
    sme_index = idx;
    tick();
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;
    check_eq({tag, "_resv"}, 64'(res_valid), 64'd1);
    check_eq({tag, "_resid"}, 64'(res_id), 64'(id));
    check_eq({tag, "_resm"}, 64'(res_match), 64'(m));
    check_eq({tag, "_resi"}, 64'(res_index), 64'(exp_idx));
    check_eq({tag, "_rese"}, 64'(res_err), 64'd0);
    check_eq({tag, "_strrdy0"}, 64'(str_ready), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq({tag, "_resv_done"}, 64'(res_valid), 64'd0);
    check_eq({tag, "_strrdy1"}, 64'(str_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    str_we = 1'b0; str_addr = '0; str_data = '0; str_commit = 1'b0; str_len_in = '0;
    req_valid = '0; req_pattern = '0; req_len = '0;
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0; res_ready = 1'b0;
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_strrdy", 64'(str_ready), 64'd0);
    check_eq("rst_resv", 64'(res_valid), 64'd0);
    check_eq("rst_isstr", 64'(sme_isstring), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("idle_strrdy", 64'(str_ready), 64'd1);
    check_eq("idle_resid", 64'(res_id), 64'd0);
    check_eq("idle_resm", 64'(res_match), 64'd0);
    check_eq("idle_resi", 64'(res_index), 64'd0);
    check_eq("idle_rese", 64'(res_err), 64'd0);
    check_eq("idle_char", 64'(sme_chardata), 64'd0);

    // Empty string: no grant.
    req_valid = 4'b0001;
    #1;
    check_eq("nolen_rr", 64'(req_ready), 64'd0);
    tick();
    check_eq("nolen_idle", 64'(str_ready), 64'd1);
    req_valid = '0;

    // Test 1: "abcabc", pattern "bc".
    write_char(0, "a"); write_char(1, "b"); write_char(2, "c");
    write_char(3, "a"); write_char(4, "b"); write_char(5, "c");
    str_commit = 1'b1; str_len_in = 6'd6;
    tick();
    str_commit = 1'b0;
    tb_pat[0] = {48'h0, 8'h63, 8'h62};
    req_pattern[63:0] = tb_pat[0];
    req_len[3:0] = 4'd2;
    req_valid = 4'b0001;
    #1;
    check_eq("t1_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    check_eq("t1_rr_pulse", 64'(req_ready), 64'd0);
    expect_stream("t1", 6, tb_pat[0], 2);
    finish_job("t1", 1'b1, 5'd1, 0, 5'd1);

    // Test 2: clean string, pattern goes out at G+1.
    tb_pat[0] = {48'h0, 8'h61, 8'h63};
    req_pattern[63:0] = tb_pat[0];
    req_valid = 4'b0001;
    #1;
    check_eq("t2_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    expect_stream("t2", 0, tb_pat[0], 2);
    finish_job("t2", 1'b1, 5'd2, 0, 5'd2);

    // Test 3: all requesters, round-robin order 1,2,3,0.
    for (int r = 0; r < NREQ; r++) begin
      for (int j = 0; j < 8; j++) tb_pat[r][j*8 +: 8] = 8'(8'h30 + r*16 + j);
      req_pattern[r*64 +: 64] = tb_pat[r];
    end
    tb_len[0] = 3; tb_len[1] = 4; tb_len[2] = 8; tb_len[3] = 5;
    req_len = {4'd5, 4'd8, 4'd4, 4'd3};
    req_valid = 4'b1111;
    for (int n = 0; n < NREQ; n++) begin
      int exp_id;
      exp_id = (n + 1) % NREQ;
      #1;
      check_eq("t3_grant", 64'(req_ready), 64'(1 << exp_id));
      tick();
      expect_stream("t3", 0, tb_pat[exp_id], tb_len[exp_id]);
      if (n == NREQ - 1) req_valid = '0;
      finish_job("t3", 1'b0, 5'd7, exp_id, 5'd0);
    end

    // Test 4: result held while consumer stalls.
    req_valid = 4'b0010;
    #1;
    check_eq("t4_grant", 64'(req_ready), 64'h2);
    tick();
    expect_stream("t4", 0, tb_pat[1], tb_len[1]);
    sme_valid = 1'b1; sme_match = 1'b1; sme_index = 5'd31;
    tick();
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = 5'd0;
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      check_eq("t4_resv", 64'(res_valid), 64'd1);
      check_eq("t4_resid", 64'(res_id), 64'd1);
      check_eq("t4_resm", 64'(res_match), 64'd1);
      check_eq("t4_resi", 64'(res_index), 64'd31);
      check_eq("t4_rr", 64'(req_ready), 64'd0);
      check_eq("t4_strrdy", 64'(str_ready), 64'd0);
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("t4_done", 64'(res_valid), 64'd0);

    // Test 5a: req_len=0 gives one char; writes, commit and sme_valid while busy are ignored.
    req_len[8 +: 4] = 4'd0;
    req_valid = 4'b0100;
    #1;
    check_eq("t5a_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    check_eq("t5a_ispat", 64'(sme_ispattern), 64'd1);
    check_eq("t5a_char", 64'(sme_chardata), 64'(tb_pat[2][7:0]));
    str_we = 1'b1; str_addr = 5'd0; str_data = "z";
    str_commit = 1'b1; str_len_in = 6'd3;
    sme_valid = 1'b1; sme_match = 1'b1; sme_index = 5'd5;
    tick();
    str_we = 1'b0; str_commit = 1'b0; sme_valid = 1'b0; sme_match = 1'b0; sme_index = 5'd0;
    check_eq("t5a_wait_ispat", 64'(sme_ispattern), 64'd0);
    check_eq("t5a_wait_resv", 64'(res_valid), 64'd0);
    tick();
    check_eq("t5a_wait_resv2", 64'(res_valid), 64'd0);
    finish_job("t5a", 1'b0, 5'd0, 2, 5'd0);

    // Test 5b: req_len=12 clamps to 8.
    req_len[12 +: 4] = 4'd12;
    req_valid = 4'b1000;
    #1;
    check_eq("t5b_grant", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    expect_stream("t5b", 0, tb_pat[3], 8);
    finish_job("t5b", 1'b1, 5'd3, 3, 5'd3);

    // Test 5c: commit len 0 (clamps to 1) in the grant cycle; buffer keeps 'a'.
    req_valid = 4'b0001;
    str_commit = 1'b1; str_len_in = 6'd0;
    #1;
    check_eq("t5c_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0; str_commit = 1'b0;
    expect_stream("t5c", 1, tb_pat[0], tb_len[0]);
    finish_job("t5c", 1'b1, 5'd0, 0, 5'd0);

    // Test 5d: write + commit len 40 in one cycle; 32 chars sent, cleared tail visible.
    str_we = 1'b1; str_addr = 5'd31; str_data = "Q";
    str_commit = 1'b1; str_len_in = 6'd40;
    tick();
    str_we = 1'b0; str_commit = 1'b0;
    tb_buf[31] = "Q";
    req_valid = 4'b0010;
    #1;
    check_eq("t5d_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    expect_stream("t5d", 32, tb_pat[1], tb_len[1]);
    finish_job("t5d", 1'b1, 5'd9, 1, 5'd9);

`ifdef SME_TIMEOUT_EN
    // Test 6: no SME result; RESP with res_err at WAIT entry + TIMEOUT + 1.
    req_valid = 4'b0100;
    #1;
    check_eq("t6_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    expect_stream("t6", 0, tb_pat[2], 1);
    for (int c = 0; c <= 20; c++) begin
      check_eq("t6_waiting", 64'(res_valid), 64'd0);
      tick();
    end
    check_eq("t6_resv", 64'(res_valid), 64'd1);
    check_eq("t6_rese", 64'(res_err), 64'd1);
    check_eq("t6_resm", 64'(res_match), 64'd0);
    check_eq("t6_resi", 64'(res_index), 64'd0);
    check_eq("t6_resid", 64'(res_id), 64'd2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = 4'b1000;
    #1;
    check_eq("t6_regrant", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    expect_stream("t6_resend", 32, tb_pat[3], 8);
    finish_job("t6_resend", 1'b1, 5'd4, 3, 5'd4);
`endif

    // Mid-stream reset: everything back to idle and the string length cleared.
    req_valid = 4'b0001;
    #1;
    check_eq("mr_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    tick();
    check_eq("mr_ispat_before", 64'(sme_ispattern), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("mr_ispat", 64'(sme_ispattern), 64'd0);
    check_eq("mr_char", 64'(sme_chardata), 64'd0);
    check_eq("mr_resv", 64'(res_valid), 64'd0);
    tick();
    reset = 1'b0;
    req_valid = 4'b0001;
    #1;
    check_eq("mr_nolen_rr", 64'(req_ready), 64'd0);
    check_eq("mr_strrdy", 64'(str_ready), 64'd1);
    check_eq("mr_resm", 64'(res_match), 64'd0);
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sme_pattern_scheduler.md
Name: sme_pattern_scheduler

Overview:
- Front-end controller for the string-match engine (SME).
- Holds one host-loaded string of up to 32 chars.
- Round-robin arbitrates pattern-match jobs from NREQ requesters and streams string/pattern characters into the SME over chardata/isstring/ispattern.
- Waits for the SME valid pulse and returns match/match_index tagged with the requester id; one job outstanding at a time.

Parameters:
- NREQ, 4, number of pattern requesters (2..8)
- IDW, 2, requester id width, equal to clog2(NREQ)
- TIMEOUT, 255, max cycles in WAIT before error (used only with SME_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- str_we  in  1  string byte write strobe
- str_addr  in  5  char position 0..31
- str_data  in  8  char
- str_commit  in  1  latch str_len_in, mark string dirty
- str_len_in  in  6  string length 1..32
- str_ready  out  1  string writes/commit accepted
- req_valid  in  NREQ  job request per requester
- req_pattern  in  NREQ*64  8 chars per requester, char0 in bits [7:0]
- req_len  in  NREQ*4  pattern length
- req_ready  out  NREQ  one-hot grant pulse, pattern captured this cycle
- sme_chardata  out  8  char to SME
- sme_isstring  out  1  string char strobe
- sme_ispattern  out  1  pattern char strobe
- sme_valid  in  1  SME result valid
- sme_match  in  1  SME match flag
- sme_index  in  5  SME match_index
- res_valid  out  1  result available, held until res_ready
- res_ready  in  1  consumer accepts result
- res_id  out  IDW  requester of result
- res_match  out  1  match flag
- res_index  out  5  match index (0 when res_match=0)
- res_err  out  1  timeout flag (0 when feature off)

Behaviour:
- Reset: state IDLE; all outputs 0; string buffer cleared; str_len=0; dirty=0; rr pointer=0.
- Reset clears state at any point, including mid-stream; the SME shares the same reset.
- States: IDLE, SEND_STR, SEND_PAT, WAIT, RESP.
- str_ready=1 only in IDLE. str_we/str_commit are ignored when str_ready=0.
- str_commit: str_len_in is stored after clamping to 1..32, and dirty=1.
- str_we and str_commit in the same cycle: the write lands first; the commit covers it.
- IDLE with str_len=0: no grants.
- Grant, in IDLE with any req_valid and str_len!=0:
  - Priority starts at requester (last_grant+1) mod NREQ, then round-robin.
  - req_ready[g]=1 for exactly one cycle; pattern and length are captured.
  - Length is clamped to 1..8 (0 becomes 1, >8 becomes 8).
  - last_grant=g.
  - Next state is SEND_STR if dirty, else SEND_PAT.
  - Grant and str_commit in the same IDLE cycle: the commit applies first and dirty goes to 1 for this job.
- SEND_STR:
  - Runs str_len cycles.
  - Each cycle: sme_isstring=1 and sme_chardata=buf[k], k=0..str_len-1.
  - The last cycle clears dirty, then goes to SEND_PAT with no gap cycle.
- SEND_PAT:
  - Runs plen cycles.
  - Each cycle: sme_ispattern=1 and sme_chardata=pattern char k, with sme_isstring=0.
  - Then goes to WAIT.
- WAIT:
  - isstring=ispattern=0 and chardata=0.
  - A cycle with sme_valid=1 captures res_match, res_index and res_id, then goes to RESP.
  - res_valid rises the next cycle.
- RESP:
  - res_valid=1 and fields stable until res_valid&res_ready, then IDLE.
  - A new grant is possible no earlier than the cycle after the handshake.
- sme_valid outside WAIT is ignored.
- Latency, grant cycle G: the first SME char is at G+1; the last pattern char is at G+(dirty?str_len:0)+plen.
- Requests dropped before grant are not tracked. req_valid is only sampled in IDLE.

Optional Feature:
- Macro SME_TIMEOUT_EN.
- Defined:
  - An 8-bit-plus counter runs in WAIT.
  - If sme_valid is not seen within TIMEOUT cycles: RESP with res_err=1, res_match=0, res_index=0, and dirty=1 so the next job resends the string.
- Undefined: no counter; WAIT is unbounded; res_err tied to 0.

Test Plan:
1. Write "abcabc" (len 6) and commit; req0 pattern "bc" len 2 -> req_ready[0] pulse; 6 isstring cycles then 2 ispattern cycles; SME valid with match=1, index=1 -> res_id=0, res_match=1, res_index=1.
2. Second job from req0 with no new commit -> no isstring cycles; first ispattern at G+1.
3. req0..req3 all valid continuously with last_grant=0 -> grants in order 1,2,3,0; each next grant only after the prior res handshake.
4. res_ready held 0 for 10 cycles -> res_valid and fields stable; no grants; str_ready=0.
5. req_len=0 -> 1 pattern char sent; req_len=12 -> 8 chars sent; str_we while busy -> buffer unchanged.
6. SME_TIMEOUT_EN with TIMEOUT=20 and sme_valid never asserted -> res_err=1 at WAIT entry+21; next job resends the string.
